// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-port word RAM behind a request/ready handshake
// with programmable wait states, byte/word access and range/alignment fault checks.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic        mem_byte,
  input  logic [31:0] addr_mem,
  input  logic [31:0] din_mem,
  output logic [31:0] dout_mem,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic [31:0]       dout_q, dout_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [31:0]       mem_q [DEPTH];

  logic              fault_c;
  logic [ADDR_W-1:0] idx_c;
  logic [1:0]        lane_c;
  logic [31:0]       rdata_c;
  logic [7:0]        rbyte_c;
  logic              ram_we_c;
  logic [3:0]        ram_be_c;
  logic [31:0]       ram_wdata_c;

  // Decode of the captured request: word index, byte lane, fault and write lanes.
  assign idx_c       = addr_q[ADDR_W+1:2];
  assign lane_c      = addr_q[1:0];
  assign fault_c     = ((addr_q >> (ADDR_W + 2)) != 32'd0) ||
                       (!byte_q && (lane_c != 2'b00));
  assign rdata_c     = mem_q[idx_c];
  assign ram_be_c    = byte_q ? 4'(4'b0001 << lane_c) : 4'b1111;
  assign ram_wdata_c = byte_q ? {4{din_q[7:0]}} : din_q;

  // Little-endian byte lane select for byte loads.
  always_comb begin
    rbyte_c = rdata_c[7:0];
    case (lane_c)
      2'd0:    rbyte_c = rdata_c[7:0];
      2'd1:    rbyte_c = rdata_c[15:8];
      2'd2:    rbyte_c = rdata_c[23:16];
      default: rbyte_c = rdata_c[31:24];
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_d     = wr_q;
    byte_d   = byte_q;
    dout_d   = dout_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    ram_we_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          addr_d  = addr_mem;
          din_d   = din_mem;
          wr_d    = mem_wr;
          byte_d  = mem_byte;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES != 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        ready_d = 1'b1;
        err_d   = fault_c;
        state_d = S_RESP;
        if (fault_c) begin
          dout_d = 32'd0;
        end else if (wr_q) begin
          ram_we_c = 1'b1;
        end else if (byte_q) begin
          dout_d = {24'd0, rbyte_c};
        end else begin
          dout_d = rdata_c;
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!mem_en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control, captured request and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM array: per-byte write enables, contents survive reset, reset blocks a pending store.
  always_ff @(posedge clk) begin
    if (ram_we_c && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be_c[b]) mem_q[idx_c][8*b +: 8] <= ram_wdata_c[8*b +: 8];
      end
    end
  end

  assign dout_mem  = dout_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_busy  = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-addressed reference memory model,
// per-cycle output comparison, directed corner cases and randomized transactions.
module tb_data_mem_ctrl;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned WAIT_CYCLES = 1;
  localparam int unsigned BYTES       = 4 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_wr;
  logic        mem_byte;
  logic [31:0] addr_mem;
  logic [31:0] din_mem;
  logic [31:0] dout_mem;
  logic        mem_ready;
  logic        mem_err;
  logic        mem_busy;

  data_mem_ctrl #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_byte  (mem_byte),
    .addr_mem  (addr_mem),
    .din_mem   (din_mem),
    .dout_mem  (dout_mem),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .mem_busy  (mem_busy)
  );

  always #5 clk = ~clk;

  // Reference state: memory as a flat byte array plus expected outputs for the current cycle.
  logic [7:0]  mem_b [BYTES];
  logic [31:0] exp_dout;
  logic        exp_ready;
  logic        exp_err;
  logic        exp_busy;
  bit          chk_en;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one transaction to the reference model; returns whether it faults.
  function automatic logic model_txn(input logic wr, input logic byt,
                                     input logic [31:0] a, input logic [31:0] d);
    logic [9:0] ba;
    logic       flt;
    ba  = a[9:0];
    flt = (a >= BYTES) || (!byt && ((a & 32'd3) != 32'd0));
    if (flt) begin
      exp_dout = 32'd0;
    end else if (wr) begin
      if (byt) mem_b[ba] = d[7:0];
      else for (int i = 0; i < 4; i++) mem_b[ba + 10'(i)] = 8'(d >> (8 * i));
    end else if (byt) begin
      exp_dout = {24'd0, mem_b[ba]};
    end else begin
      exp_dout = {mem_b[ba + 10'd3], mem_b[ba + 10'd2], mem_b[ba + 10'd1], mem_b[ba]};
    end
    return flt;
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", dout_mem, exp_dout);
      chk("ready", {31'd0, mem_ready}, {31'd0, exp_ready});
      chk("busy", {31'd0, mem_busy}, {31'd0, exp_busy});
      if (exp_ready || !exp_busy) chk("err", {31'd0, mem_err}, {31'd0, exp_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    addr_mem = $urandom;
    din_mem  = $urandom;
    mem_wr   = 1'($urandom_range(0, 1));
    mem_byte = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    mem_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      scramble();
      tick();
    end
  endtask

  // Full handshake: request, wait states, access, ready pulse, hold, release.
  task automatic txn(input logic wr, input logic byt, input logic [31:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic er);
    logic e;
    mem_en = 1'b1; mem_wr = wr; mem_byte = byt; addr_mem = a; din_mem = d;
    tick();
    exp_busy = 1'b1; exp_ready = 1'b0; exp_err = 1'b0;
    scramble();
    for (int j = 0; j < int'(WAIT_CYCLES); j++) begin
      tick();
      scramble();
    end
    tick();
    e = model_txn(wr, byt, a, d);
    exp_ready = 1'b1; exp_err = e;
    rd = dout_mem; er = mem_err;
    scramble();
    tick();
    exp_ready = 1'b0; exp_err = 1'b0;
    for (int j = 1; j < hold; j++) begin
      scramble();
      tick();
    end
    mem_en = 1'b0;
    tick();
    exp_busy = 1'b0;
  endtask

  // Request aborted by reset sampled on the n-th edge after acceptance.
  task automatic txn_rst(input logic wr, input logic byt, input logic [31:0] a,
                         input logic [31:0] d, input int n);
    mem_en = 1'b1; mem_wr = wr; mem_byte = byt; addr_mem = a; din_mem = d;
    tick();
    exp_busy = 1'b1; exp_ready = 1'b0;
    for (int j = 1; j < n; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_en = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic        er;
    logic        wr;
    logic        byt;
    int unsigned r;

    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_byte = 1'b0;
    addr_mem = 32'd0; din_mem = 32'd0;
    exp_dout = 32'd0; exp_ready = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_dout", dout_mem, 32'd0);
    chk("rst_busy", {31'd0, mem_busy}, 32'd0);
    rst = 1'b0;

    // Known contents everywhere before any loads.
    for (int i = 0; i < int'(BYTES / 4); i++) txn(1'b1, 1'b0, 32'(i * 4), $urandom, 0, rd, er);

    // Word store then load.
    txn(1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 0, rd, er);
    chk("wst_err", {31'd0, er}, 32'd0);
    txn(1'b0, 1'b0, 32'h010, 32'd0, 0, rd, er);
    chk("wld_data", rd, 32'hDEADBEEF);

    // Byte merge.
    txn(1'b1, 1'b1, 32'h013, 32'h000000A5, 0, rd, er);
    txn(1'b0, 1'b0, 32'h010, 32'd0, 0, rd, er);
    chk("merge_word", rd, 32'hA5ADBEEF);
    txn(1'b0, 1'b1, 32'h012, 32'd0, 0, rd, er);
    chk("merge_byte", rd, 32'h000000AD);

    // Faults.
    txn(1'b1, 1'b0, 32'h000, 32'h11223344, 0, rd, er);
    txn(1'b0, 1'b0, 32'h402, 32'd0, 0, rd, er);
    chk("oor_ld_err", {31'd0, er}, 32'd1);
    chk("oor_ld_data", rd, 32'd0);
    txn(1'b1, 1'b0, 32'h400, 32'h12345678, 0, rd, er);
    chk("oor_st_err", {31'd0, er}, 32'd1);
    txn(1'b0, 1'b0, 32'h000, 32'd0, 0, rd, er);
    chk("oor_st_clean", rd, 32'h11223344);
    txn(1'b0, 1'b1, 32'h3FF, 32'd0, 0, rd, er);
    chk("top_byte_err", {31'd0, er}, 32'd0);
    txn(1'b0, 1'b0, 32'h031, 32'd0, 0, rd, er);
    chk("misalign_err", {31'd0, er}, 32'd1);

    // Long hold yields a single completion; release then a normal request.
    txn(1'b1, 1'b0, 32'h040, 32'h0BADF00D, 7, rd, er);
    idle(1);
    txn(1'b0, 1'b0, 32'h040, 32'd0, 0, rd, er);
    chk("hold_next", rd, 32'h0BADF00D);

    // Reset during WAIT and on the ACCESS edge: store dropped, contents kept.
    txn(1'b1, 1'b0, 32'h020, 32'h55AA55AA, 0, rd, er);
    txn_rst(1'b1, 1'b0, 32'h020, 32'hCAFEF00D, 1);
    chk("rst_wait_dout", dout_mem, 32'd0);
    txn(1'b0, 1'b0, 32'h020, 32'd0, 0, rd, er);
    chk("rst_wait_mem", rd, 32'h55AA55AA);
    txn_rst(1'b1, 1'b0, 32'h020, 32'hCAFEF00D, 1 + int'(WAIT_CYCLES));
    txn(1'b0, 1'b0, 32'h020, 32'd0, 0, rd, er);
    chk("rst_acc_mem", rd, 32'h55AA55AA);

    // Randomized traffic with boundary-biased addresses.
    for (int t = 0; t < 400; t++) begin
      wr  = 1'($urandom_range(0, 1));
      byt = ($urandom_range(0, 3) == 0);
      r   = $urandom_range(0, 99);
      if (r < 8)       a = $urandom;
      else if (r < 16) a = 32'h3FC + 32'($urandom_range(0, 7));
      else             a = 32'($urandom_range(0, BYTES - 1));
      if (!byt && ($urandom_range(0, 9) < 8)) a = a & ~32'd3;
      txn(wr, byt, a, $urandom, int'($urandom_range(0, 3)), rd, er);
      idle(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The parameter ADDR_W SHALL default to 8 and SHALL be log2 of the RAM depth in 32-bit words, giving 256 words and 1 KB.
REQ-002 The parameter WAIT_CYCLES SHALL default to 1 and SHALL set the number of wait states inserted before each access (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous and active-high, with priority over all other inputs.
REQ-005 mem_en  input  1  SHALL be the request from the core; a level held high until mem_ready is seen.
REQ-006 mem_wr  input  1  SHALL select store (1) or load (0).
REQ-007 mem_byte  input  1  SHALL select byte access (1) or word access (0).
REQ-008 addr_mem  input  32  SHALL carry the byte address.
REQ-009 din_mem  input  32  SHALL carry store data; byte stores use [7:0].
REQ-010 dout_mem  output  32  SHALL carry load data to the core.
REQ-011 mem_ready  output  1  SHALL pulse for exactly one cycle on transaction completion.
REQ-012 mem_err  output  1  SHALL be asserted alongside mem_ready when the transaction faulted.
REQ-013 mem_busy  output  1  SHALL be 1 in every state except IDLE.

Function
REQ-014 The block SHALL implement the state machine IDLE, WAIT, ACCESS, RESP, HOLD.
REQ-015 In IDLE with mem_en=1, the block SHALL capture addr_mem, din_mem, mem_wr and mem_byte, then go to WAIT if WAIT_CYCLES>0, else to ACCESS.
REQ-016 WAIT SHALL count WAIT_CYCLES cycles and then go to ACCESS.
REQ-017 The block SHALL ignore inputs outside IDLE; captured values are used throughout.
REQ-018 The block SHALL flag a fault when captured addr[31:ADDR_W+2] is nonzero (out of range).
REQ-019 The block SHALL also flag a fault on a word access with addr[1:0] nonzero (misaligned).
REQ-020 A faulted transaction SHALL not touch the RAM, SHALL drive dout_mem to 0x00000000, and SHALL set mem_err=1 in RESP.
REQ-021 ACCESS SHALL last one cycle, perform the RAM read or write at word index addr[ADDR_W+1:2], and then go to RESP.
REQ-022 Word store SHALL write all 32 bits.
REQ-023 Byte store SHALL write din_mem[7:0] into the little-endian lane addr[1:0] and leave the other lanes unchanged.
REQ-024 Word load SHALL return the full word.
REQ-025 Byte load SHALL return lane addr[1:0] zero-extended to 32 bits.
REQ-026 Loads SHALL update dout_mem on the ACCESS-to-RESP edge; dout_mem SHALL hold until the next completed load or fault.
REQ-027 Stores SHALL leave dout_mem unchanged.
REQ-028 RESP SHALL assert mem_ready=1, with mem_err per the fault check, for one cycle and then go to HOLD.
REQ-029 HOLD SHALL return to IDLE on the first edge where mem_en=0, so one assertion of mem_en yields exactly one transaction.
REQ-030 Latency: with the request sampled at edge k, mem_ready SHALL be high in the cycle after edge k+WAIT_CYCLES+1.
REQ-031 The RAM array SHALL be inferred block/distributed RAM with a single port and no reset of its contents.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set state=IDLE and clear the wait counter.
REQ-033 When rst=1 at an edge, the block SHALL clear the captured request registers to 0.
REQ-034 When rst=1 at an edge, dout_mem SHALL be 0, mem_ready 0, mem_err 0 and mem_busy 0.
REQ-035 If rst=1 on the ACCESS edge, the pending store SHALL NOT be performed, and RAM contents SHALL otherwise persist across reset.
REQ-036 After reset the block SHALL accept a request in the first cycle where rst=0 and mem_en=1.

Verification (ADDR_W=8, WAIT_CYCLES=1)
REQ-037 Word store then load: store 0xDEADBEEF to 0x010 gives mem_ready 2 edges after sampling with mem_err=0; a word load of 0x010 then returns dout_mem=0xDEADBEEF.
REQ-038 Byte merge: a byte store of din=0x000000A5 to 0x013 makes a word load of 0x010 return 0xA5ADBEEF; a byte load of 0x012 returns 0x000000AD.
REQ-039 Faults: a word load at 0x00000402 gives mem_err=1 and dout_mem=0; a word store of 0x12345678 to 0x00000400 gives mem_err=1 and a word load of 0x000 is unchanged; a byte load at 0x3FF gives mem_err=0.
REQ-040 Hold: mem_en held high for 6 cycles after mem_ready gives no second mem_ready; after mem_en drops for 1 cycle, the next request completes normally.
REQ-041 Reset mid-operation: rst=1 during WAIT of a store of 0xCAFEF00D to 0x020 returns all outputs to 0, and a subsequent load of 0x020 returns the prior contents.
REQ-042 Busy ignore: with mem_busy=1, changing addr_mem/din_mem/mem_wr does not affect the in-flight transaction's address, data or direction.
